// File: rtl/seven_seg_capture_if.sv
// seven_seg_capture_if
//   Bundle between a multiplexed 7-segment display (or its driver) and the
//   capture block.
//   master: display side and frame consumer (drives seg_n, an_n, frame_ready)
//   slave : capture block (drives frame_valid, digits_out, digit_err, overrun)
//   seg_n       segment bus, active-low, bit0=a .. bit6=g
//   an_n        digit enables, active-low, bit k = digit k
//   frame_ready consumer accepts the frame while frame_valid is high
//   frame_valid digits_out/digit_err hold a complete frame
//   digits_out  digit k at [4k+3:4k]
//   digit_err   bit k set: digit k pattern was not a legal digit
//   overrun     one-cycle pulse when a completed frame was dropped
interface seven_seg_capture_if #(
  parameter int NUM_DIGITS = 4
);
  logic [6:0]              seg_n;
  logic [NUM_DIGITS-1:0]   an_n;
  logic                    frame_ready;
  logic                    frame_valid;
  logic [4*NUM_DIGITS-1:0] digits_out;
  logic [NUM_DIGITS-1:0]   digit_err;
  logic                    overrun;

  modport master (
    output seg_n, an_n, frame_ready,
    input  frame_valid, digits_out, digit_err, overrun
  );

  modport slave (
    input  seg_n, an_n, frame_ready,
    output frame_valid, digits_out, digit_err, overrun
  );
endinterface

// File: rtl/seven_seg_capture.sv
// seven_seg_capture
//   Reads back a multiplexed 7-segment display. Synchronises the segment bus
//   and digit enables, waits for each digit pattern to be stable for
//   STABLE_CYCLES samples, decodes it to a nibble and assembles complete
//   NUM_DIGITS-digit frames offered over a valid/ready handshake.
//   clk  system clock, rising edge
//   rst  asynchronous reset, active-high
//   bus  slave side of seven_seg_capture_if (see interface header)
module seven_seg_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst,
  seven_seg_capture_if.slave bus
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] C_STABLE = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] C_PRE    = CW'(STABLE_CYCLES - 1);

  logic [6:0]              r_seg_s1, r_seg_s2, r_seg_prev;
  logic [NUM_DIGITS-1:0]   r_an_s1, r_an_s2, r_an_prev;
  logic [CW-1:0]           r_count;
  logic [NUM_DIGITS-1:0]   r_seen;
  logic [4*NUM_DIGITS-1:0] r_shadow_digits;
  logic [NUM_DIGITS-1:0]   r_shadow_err;
  logic                    r_frame_valid;
  logic [4*NUM_DIGITS-1:0] r_digits;
  logic [NUM_DIGITS-1:0]   r_err;
  logic                    r_overrun;

  logic                    w_eligible;
  logic                    w_same;
  logic                    w_capture;
  logic                    w_complete;
  logic [IW-1:0]           w_slot;
  logic [3:0]              w_nibble;
  logic                    w_bad;
  logic [CW-1:0]           w_count_next;
  logic [NUM_DIGITS-1:0]   w_seen_next;

  // Two-flop synchroniser plus one more stage holding the previous sample
  // for the stability comparison.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg_s1   <= '1;
      r_seg_s2   <= '1;
      r_seg_prev <= '1;
      r_an_s1    <= '1;
      r_an_s2    <= '1;
      r_an_prev  <= '1;
    end else begin
      r_seg_s1   <= bus.seg_n;
      r_seg_s2   <= r_seg_s1;
      r_seg_prev <= r_seg_s2;
      r_an_s1    <= bus.an_n;
      r_an_s2    <= r_an_s1;
      r_an_prev  <= r_an_s2;
    end
  end

  // Only a single active enable identifies a digit; blanking and overlap
  // (two or more enables low) are both ignored.
  assign w_eligible = $onehot(~r_an_s2);
  assign w_same     = (r_seg_s2 == r_seg_prev) && (r_an_s2 == r_an_prev);
  assign w_capture  = w_eligible && w_same && (r_count == C_PRE);
  assign w_complete = &r_seen;

  always_comb begin
    w_slot = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (!r_an_s2[k]) w_slot = IW'(k);
    end
  end

  always_comb begin
    w_bad = 1'b0;
    case (r_seg_s2)
      7'b1000000: w_nibble = 4'h0;
      7'b1111001: w_nibble = 4'h1;
      7'b0100100: w_nibble = 4'h2;
      7'b0110000: w_nibble = 4'h3;
      7'b0011001: w_nibble = 4'h4;
      7'b0010010: w_nibble = 4'h5;
      7'b0000010: w_nibble = 4'h6;
      7'b1011000: w_nibble = 4'h7;
      7'b0000000: w_nibble = 4'h8;
      7'b0010000: w_nibble = 4'h9;
      7'b1111111: w_nibble = 4'hF;
      default: begin
        w_nibble = 4'hE;
        w_bad    = 1'b1;
      end
    endcase
  end

  // Saturating at STABLE_CYCLES means the capture compare (STABLE-1 ->
  // STABLE) fires once per stable period.
  always_comb begin
    w_count_next = '0;
    if (w_eligible) begin
      if (!w_same)                  w_count_next = CW'(1);
      else if (r_count == C_STABLE) w_count_next = C_STABLE;
      else                          w_count_next = r_count + 1'b1;
    end
  end

  // A capture on the same edge the frame is offered starts the next frame.
  always_comb begin
    w_seen_next = w_complete ? '0 : r_seen;
    if (w_capture) w_seen_next[w_slot] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count         <= '0;
      r_seen          <= '0;
      r_shadow_digits <= '0;
      r_shadow_err    <= '0;
    end else begin
      r_count <= w_count_next;
      r_seen  <= w_seen_next;
      if (w_capture) begin
        r_shadow_digits[w_slot*4 +: 4] <= w_nibble;
        r_shadow_err[w_slot]           <= w_bad;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_valid <= 1'b0;
      r_digits      <= '0;
      r_err         <= '0;
      r_overrun     <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_complete) begin
        if (!r_frame_valid || bus.frame_ready) begin
          r_digits      <= r_shadow_digits;
          r_err         <= r_shadow_err;
          r_frame_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_frame_valid && bus.frame_ready) begin
        r_frame_valid <= 1'b0;
      end
    end
  end

  assign bus.frame_valid = r_frame_valid;
  assign bus.digits_out  = r_digits;
  assign bus.digit_err   = r_err;
  assign bus.overrun     = r_overrun;
endmodule
